// File: rtl/tdes_seq_pkg.sv
// -----------------------------------------------------------------------------
// tdes_seq_pkg
// Shared types and constants for the 3DES round/pass sequencer:
//   - seq_state_e : sequencer FSM states (IDLE, RUN, DONE)
//   - DEF_ROUNDS / DEF_PASSES : default geometry (16 rounds, 3 passes = EDE)
//   - MODE_ENC / MODE_DEC : operation mode encodings
//   - key_map() : subkey index for a round given the pass direction
// No ports (package).
// -----------------------------------------------------------------------------
package tdes_seq_pkg;

  localparam int DEF_ROUNDS = 16;
  localparam int DEF_PASSES = 3;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Encrypt-direction passes walk the key schedule forwards, decrypt-direction
  // passes walk it backwards.
  function automatic int unsigned key_map(input int unsigned rounds,
                                          input int unsigned round,
                                          input logic        dir);
    int unsigned k;
    if (dir == MODE_DEC) begin
      k = rounds - 32'd1 - round;
    end else begin
      k = round;
    end
    return k;
  endfunction

endpackage

// File: rtl/tdes_round_cnt.sv
// -----------------------------------------------------------------------------
// tdes_round_cnt
// Wrap counter: counts 0..TERM while enabled, returns to 0 after TERM.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (priority over en_i)
//   en_i       : advance by one
//   cnt_o      : current count (registered)
//   wrap_o     : high when an enabled advance leaves TERM (count returns to 0)
// -----------------------------------------------------------------------------
module tdes_round_cnt #(
  parameter int WIDTH = 4,
  parameter int TERM  = 15
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear, advance with wrap at TERM, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (en_i) begin
      if (cnt_q == TERM_V) begin
        cnt_d = {WIDTH{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i & ~clr_i & (cnt_q == TERM_V);

endmodule

// File: rtl/tdes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tdes_round_sequencer
// Two-level round/pass sequencer for the 3DES datapath. On start it latches
// the mode and issues ROUNDS x PASSES rounds, each with round index, subkey
// index (ascending on encrypt-direction passes, descending on decrypt ones)
// and the key select for the pass, then pulses done for one cycle.
// Optional feature macro: TDES_SEQ_STALL_CNT_EN adds a saturating 16-bit
// counter of stalled RUN cycles on port stall_cnt.
// Ports:
//   clk, n_rst  : clock, asynchronous active-low reset
//   start       : begin an operation (only honoured in IDLE)
//   mode        : 0 encrypt (EDE), 1 decrypt (DED), latched at start
//   stall       : hold the sequence; the next cycle carries no valid round
//   abort       : return to IDLE next cycle, no done
//   busy        : operation in progress (RUN or DONE)
//   round_valid : round_idx/key_idx/pass_idx/key_sel describe a live round
//   round_idx   : round within the pass
//   key_idx     : subkey index for this round
//   pass_idx    : pass number
//   key_sel     : key (K1 = 0) used by this pass
//   pass_done   : last round of a pass is being issued
//   done        : one-cycle end-of-operation pulse
//   stall_cnt   : (TDES_SEQ_STALL_CNT_EN only) stalled RUN cycles
// -----------------------------------------------------------------------------
module tdes_round_sequencer
  import tdes_seq_pkg::*;
#(
  parameter int ROUNDS    = DEF_ROUNDS,
  parameter int PASSES    = DEF_PASSES,
  parameter int CNT_BITS  = $clog2(ROUNDS),
  parameter int PASS_BITS = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 stall,
  input  logic                 abort,
  output logic                 busy,
  output logic                 round_valid,
  output logic [CNT_BITS-1:0]  round_idx,
  output logic [CNT_BITS-1:0]  key_idx,
  output logic [PASS_BITS-1:0] pass_idx,
  output logic [PASS_BITS-1:0] key_sel,
  output logic                 pass_done,
  output logic                 done
`ifdef TDES_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam logic [CNT_BITS-1:0]  ROUND_LAST = CNT_BITS'(ROUNDS - 1);
  localparam logic [PASS_BITS-1:0] PASS_LAST  = PASS_BITS'(PASSES - 1);

  seq_state_e           state_q;
  seq_state_e           state_d;
  logic                 mode_q;
  logic                 mode_d;
  logic                 valid_q;
  logic                 valid_d;

  logic                 cnt_clr;
  logic                 round_en;
  logic [CNT_BITS-1:0]  round_cnt;
  logic                 round_wrap;
  logic [PASS_BITS-1:0] pass_cnt;
  logic                 pass_wrap;
  logic                 run;
  logic                 dir;

  assign run = (state_q == ST_RUN);

  // Counters sit at zero outside RUN so a new operation always starts at
  // round 0 of pass 0. They advance once per round actually issued, so a
  // stall bubble leaves them parked on the next round to issue.
  assign cnt_clr  = abort | ~run;
  assign round_en = run & valid_q;

  tdes_round_cnt #(
    .WIDTH (CNT_BITS),
    .TERM  (ROUNDS - 1)
  ) u_round_cnt (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (cnt_clr),
    .en_i   (round_en),
    .cnt_o  (round_cnt),
    .wrap_o (round_wrap)
  );

  tdes_round_cnt #(
    .WIDTH (PASS_BITS),
    .TERM  (PASSES - 1)
  ) u_pass_cnt (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (cnt_clr),
    .en_i   (round_wrap),
    .cnt_o  (pass_cnt),
    .wrap_o (pass_wrap)
  );

  // Next state, mode latch and registered round_valid.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            mode_d  = mode;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // pass_wrap means the final round of the final pass was issued.
          if (pass_wrap) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    valid_d = (state_d == ST_RUN) & ~stall;
  end

  // FSM, mode and valid registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ENC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  // Direction alternates per pass, starting from the latched mode.
  assign dir = mode_q ^ pass_cnt[0];

  // Output decode; indices are forced to zero whenever not running.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    round_valid = valid_q;
    pass_done   = valid_q & (round_cnt == ROUND_LAST);
    if (run) begin
      round_idx = round_cnt;
      key_idx   = CNT_BITS'(key_map(32'(ROUNDS), 32'(round_cnt), dir));
      pass_idx  = pass_cnt;
      key_sel   = (mode_q == MODE_DEC) ? (PASS_LAST - pass_cnt) : pass_cnt;
    end else begin
      round_idx = {CNT_BITS{1'b0}};
      key_idx   = {CNT_BITS{1'b0}};
      pass_idx  = {PASS_BITS{1'b0}};
      key_sel   = {PASS_BITS{1'b0}};
    end
  end

`ifdef TDES_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Stalled RUN cycles are the bubbles where round_valid is low.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start && !abort) begin
      stall_cnt_d = 16'h0000;
    end else if (run && !valid_q && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tdes_round_sequencer.sv
module tb_tdes_round_sequencer;

  localparam int RA = 16;
  localparam int PA = 3;
  localparam int RB = 4;
  localparam int PB = 1;

  typedef struct {
    bit is_done;
    int rnd;
    int key;
    int pas;
    int ksel;
    bit pdone;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // DUT A (default geometry)
  logic       start_a = 1'b0, mode_a = 1'b0, stall_a = 1'b0, abort_a = 1'b0;
  logic       a_busy, a_round_valid, a_pass_done, a_done;
  logic [3:0] a_round_idx, a_key_idx;
  logic [1:0] a_pass_idx, a_key_sel;
  // DUT B (ROUNDS=4, PASSES=1)
  logic       start_b = 1'b0, mode_b = 1'b0;
  logic       b_busy, b_round_valid, b_pass_done, b_done;
  logic [1:0] b_round_idx, b_key_idx;
  logic [0:0] b_pass_idx, b_key_sel;
`ifdef TDES_SEQ_STALL_CNT_EN
  logic [15:0] a_stall_cnt, b_stall_cnt;
`endif

  exp_t q_a[$];
  exp_t m_e;
  bit   mon_en_a = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdes_round_sequencer u_dut_a (
    .clk(clk), .n_rst(n_rst), .start(start_a), .mode(mode_a), .stall(stall_a),
    .abort(abort_a), .busy(a_busy), .round_valid(a_round_valid),
    .round_idx(a_round_idx), .key_idx(a_key_idx), .pass_idx(a_pass_idx),
    .key_sel(a_key_sel), .pass_done(a_pass_done), .done(a_done)
`ifdef TDES_SEQ_STALL_CNT_EN
    , .stall_cnt(a_stall_cnt)
`endif
  );

  tdes_round_sequencer #(.ROUNDS(RB), .PASSES(PB)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .start(start_b), .mode(mode_b), .stall(1'b0),
    .abort(1'b0), .busy(b_busy), .round_valid(b_round_valid),
    .round_idx(b_round_idx), .key_idx(b_key_idx), .pass_idx(b_pass_idx),
    .key_sel(b_key_sel), .pass_done(b_pass_done), .done(b_done)
`ifdef TDES_SEQ_STALL_CNT_EN
    , .stall_cnt(b_stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: round r of pass p, straight from the sequencing rules.
  function automatic exp_t model_round(input int R, input int P, input bit m,
                                       input int p, input int r);
    exp_t e;
    bit   d;
    d       = m ^ p[0];
    e.is_done = 1'b0;
    e.rnd   = r;
    e.key   = d ? (R - 1 - r) : r;
    e.pas   = p;
    e.ksel  = m ? (P - 1 - p) : p;
    e.pdone = (r == R - 1);
    return e;
  endfunction

  function automatic exp_t done_entry();
    exp_t e;
    e.is_done = 1'b1; e.rnd = 0; e.key = 0; e.pas = 0; e.ksel = 0; e.pdone = 1'b0;
    return e;
  endfunction

  // Scoreboard monitor for DUT A.
  always @(negedge clk) begin
    if (mon_en_a && n_rst) begin
      if (a_round_valid || a_done) begin
        if (q_a.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: valid=%0b done=%0b, expected nothing (cycle %0d)",
                   a_round_valid, a_done, cyc);
        end else begin
          m_e = q_a.pop_front();
          chk("sb_done", a_done, m_e.is_done);
          chk("sb_valid", a_round_valid, !m_e.is_done);
          if (!m_e.is_done) begin
            chk("sb_round_idx", a_round_idx, m_e.rnd);
            chk("sb_key_idx", a_key_idx, m_e.key);
            chk("sb_pass_idx", a_pass_idx, m_e.pas);
            chk("sb_key_sel", a_key_sel, m_e.ksel);
            chk("sb_pass_done", a_pass_done, m_e.pdone);
          end
        end
      end else if (a_busy && q_a.size() > 0 && !q_a[0].is_done) begin
        chk("hold_round_idx", a_round_idx, q_a[0].rnd);
        chk("hold_pass_idx", a_pass_idx, q_a[0].pas);
        chk("hold_pass_done", a_pass_done, 0);
      end
    end
  end

  task automatic chk_a_idle(input string tag);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_valid"}, a_round_valid, 0);
    chk({tag, "_round_idx"}, a_round_idx, 0);
    chk({tag, "_key_idx"}, a_key_idx, 0);
    chk({tag, "_pass_idx"}, a_pass_idx, 0);
    chk({tag, "_key_sel"}, a_key_sel, 0);
    chk({tag, "_pass_done"}, a_pass_done, 0);
    chk({tag, "_done"}, a_done, 0);
  endtask

  task automatic run_a(input bit m, input bit toggle, input int stall_pct,
                       input int stall_k, input int stall_len, input int abort_k,
                       input bit noise);
    int t, vcount, bubbles, stall_left, done_cyc, n_exp;
    bit got_done, aborted, s;
    n_exp = (abort_k >= 0) ? abort_k + 1 : RA * PA;
    for (int i = 0; i < n_exp; i++) q_a.push_back(model_round(RA, PA, m, i / RA, i % RA));
    if (abort_k < 0) q_a.push_back(done_entry());
    vcount = 0; bubbles = 0; stall_left = 0; done_cyc = 0; got_done = 0; aborted = 0;
    @(negedge clk);
    start_a = 1'b1; mode_a = m; stall_a = 1'b0; abort_a = 1'b0; t = cyc;
    for (int i = 0; i < 400 && !got_done && !aborted; i++) begin
      @(negedge clk);
      start_a = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (toggle) mode_a = 1'($urandom_range(0, 1));
      if (a_done) begin
        got_done = 1; done_cyc = cyc;
      end else begin
        if (a_round_valid) vcount++;
        if (abort_k >= 0 && a_round_valid && vcount == abort_k + 1) begin
          abort_a = 1'b1; start_a = 1'b1; stall_a = 1'b1; aborted = 1;
        end else begin
          s = 1'b0;
          if (stall_left > 0) begin
            s = 1'b1; stall_left--;
          end else if (stall_k >= 0 && a_round_valid && vcount == stall_k) begin
            s = 1'b1; stall_left = stall_len - 1;
          end else if ($urandom_range(0, 99) < stall_pct) begin
            s = 1'b1;
          end
          stall_a = s;
          // A stall while the last round is on the bus costs nothing.
          if (s && !(a_round_valid && vcount == RA * PA)) bubbles++;
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      abort_a = 1'b0; start_a = 1'b0; stall_a = 1'b0;
      chk_a_idle("abort");
      repeat (3) @(negedge clk);
      chk("abort_no_done_busy", a_busy, 0);
    end else if (got_done) begin
      start_a = 1'b1; stall_a = 1'b0;   // start in the DONE cycle must be ignored
      chk("done_cycle", done_cyc, t + 1 + RA * PA + bubbles);
      @(negedge clk);
      start_a = 1'b0;
      chk_a_idle("after_done");
`ifdef TDES_SEQ_STALL_CNT_EN
      chk("stall_cnt", a_stall_cnt, bubbles);
`endif
    end else begin
      chk("done_timeout", 0, 1);
      start_a = 1'b0; stall_a = 1'b0;
    end
    chk("sb_drained", q_a.size(), 0);
  endtask

  task automatic run_b(input bit m);
    exp_t e;
    @(negedge clk);
    start_b = 1'b1; mode_b = m;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < RB; k++) begin
      e = model_round(RB, PB, m, 0, k);
      chk("b_valid", b_round_valid, 1);
      chk("b_round_idx", b_round_idx, e.rnd);
      chk("b_key_idx", b_key_idx, e.key);
      chk("b_key_sel", b_key_sel, e.ksel);
      chk("b_pass_idx", b_pass_idx, e.pas);
      chk("b_pass_done", b_pass_done, e.pdone);
      chk("b_no_early_done", b_done, 0);
      @(negedge clk);
    end
    chk("b_done", b_done, 1);
    chk("b_done_valid", b_round_valid, 0);
    @(negedge clk);
    chk("b_idle_busy", b_busy, 0);
    chk("b_idle_done", b_done, 0);
`ifdef TDES_SEQ_STALL_CNT_EN
    chk("b_stall_cnt", b_stall_cnt, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk_a_idle("reset");
    chk("reset_b_busy", b_busy, 0);
    chk("reset_b_valid", b_round_valid, 0);

    run_a(1'b0, 1'b0, 0, -1, 0, -1, 1'b0);            // encrypt, clean
    run_a(1'b1, 1'b0, 0, -1, 0, -1, 1'b0);            // decrypt, clean
    run_a(1'b1, 1'b1, 0, -1, 0, -1, 1'b0);            // decrypt, mode toggling
    run_a(1'b0, 1'b0, 0, RA + 8, 5, -1, 1'b0);        // 5-cycle stall in pass 1
    run_a(1'b1, 1'b0, 0, -1, 0, 2 * RA + 3, 1'b0);    // abort at pass 2 round 3
    run_a(1'b0, 1'b0, 0, -1, 0, -1, 1'b0);            // full run after abort
    run_a(1'b0, 1'b0, 0, -1, 0, -1, 1'b1);            // start noise during RUN

    // Asynchronous reset in the middle of an operation.
    mon_en_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1; mode_a = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", a_busy, 1);
    n_rst = 1'b0;
    #1;
    chk("async_reset_busy", a_busy, 0);
    chk("async_reset_valid", a_round_valid, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    mon_en_a = 1'b1;
    chk_a_idle("post_reset");
    run_a(1'b1, 1'b0, 0, -1, 0, -1, 1'b0);

    for (int i = 0; i < 4; i++)
      run_a(1'($urandom_range(0, 1)), 1'b1, 25, -1, 0, -1, 1'b1);

    run_b(1'b0);
    run_b(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
